instr_aligner: RTL and testbench



---
 rtl/instr_aligner_pkg.sv | 25 ++
 rtl/instr_aligner_compressed_decoder.sv | 94 +++++++++
 rtl/instr_aligner.sv | 154 +++++++++++++++
 tb/tb_instr_aligner.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_aligner_pkg.sv
// Shared types and constants for the fetch-side instruction aligner.
package instr_aligner_pkg;

    typedef enum logic [1:0] {
        ALIGNED = 2'd0,
        RESID   = 2'd1,
        SKIP    = 2'd2
    } align_state_e;

    localparam logic [31:0] BOOT_ADDR_DEFAULT = 32'h0000_0080;

    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_OP_IMM = 7'h13;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_JAL    = 7'h6f;

    function automatic logic is_compressed(input logic [15:0] half);
        return half[1:0] != 2'b11;
    endfunction

endpackage

// File: rtl/instr_aligner_compressed_decoder.sv
// RV32C expander: maps a 16-bit compressed instruction to its 32-bit form; 32-bit input passes through.
module compressed_decoder
    import instr_aligner_pkg::*;
(
    input  logic [31:0] instr_i,
    output logic [31:0] instr_o,
    output logic        is_compressed_o,
    output logic        illegal_instr_o
);

    logic [15:0] c;

    assign c = instr_i[15:0];
    assign is_compressed_o = is_compressed(c);

    always_comb begin
        instr_o         = instr_i;
        illegal_instr_o = 1'b0;
        case (c[1:0])
            2'b00: begin
                case (c[15:13])
                    3'b000: begin
                        instr_o = {2'b0, c[10:7], c[12:11], c[5], c[6], 2'b00, 5'h02, 3'b000, 2'b01, c[4:2], OPC_OP_IMM};
                        illegal_instr_o = (c[12:5] == 8'h00);
                    end
                    3'b010: instr_o = {5'b0, c[5], c[12:10], c[6], 2'b00, 2'b01, c[9:7], 3'b010, 2'b01, c[4:2], OPC_LOAD};
                    3'b110: instr_o = {5'b0, c[5], c[12], 2'b01, c[4:2], 2'b01, c[9:7], 3'b010, c[11:10], c[6], 2'b00, OPC_STORE};
                    default: illegal_instr_o = 1'b1;
                endcase
            end
            2'b01: begin
                case (c[15:13])
                    3'b000: instr_o = {{6{c[12]}}, c[12], c[6:2], c[11:7], 3'b000, c[11:7], OPC_OP_IMM};
                    3'b001, 3'b101: instr_o = {c[12], c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3], {9{c[12]}}, 4'b0, ~c[15], OPC_JAL};
                    3'b010: instr_o = {{6{c[12]}}, c[12], c[6:2], 5'b0, 3'b000, c[11:7], OPC_OP_IMM};
                    3'b011: begin
                        if (c[11:7] == 5'h02) begin
                            instr_o = {{3{c[12]}}, c[4:3], c[5], c[2], c[6], 4'b0, 5'h02, 3'b000, 5'h02, OPC_OP_IMM};
                        end else begin
                            instr_o = {{15{c[12]}}, c[6:2], c[11:7], OPC_LUI};
                        end
                        illegal_instr_o = ({c[12], c[6:2]} == 6'h00);
                    end
                    3'b100: begin
                        case (c[11:10])
                            2'b00, 2'b01: begin
                                instr_o = {1'b0, c[10], 5'b0, c[6:2], 2'b01, c[9:7], 3'b101, 2'b01, c[9:7], OPC_OP_IMM};
                                illegal_instr_o = c[12];
                            end
                            2'b10: instr_o = {{6{c[12]}}, c[12], c[6:2], 2'b01, c[9:7], 3'b111, 2'b01, c[9:7], OPC_OP_IMM};
                            default: begin
                                // c.sub / c.xor / c.or / c.and; c[12]=1 encodes RV64-only ops
                                instr_o = {1'b0, (c[6:5] == 2'b00), 5'b0, 2'b01, c[4:2], 2'b01, c[9:7],
                                           (c[6:5] == 2'b00) ? 3'b000 : (c[6:5] == 2'b01) ? 3'b100 :
                                           (c[6:5] == 2'b10) ? 3'b110 : 3'b111,
                                           2'b01, c[9:7], OPC_OP};
                                illegal_instr_o = c[12];
                            end
                        endcase
                    end
                    default: instr_o = {{4{c[12]}}, c[6:5], c[2], 5'b0, 2'b01, c[9:7], 2'b00, c[13], c[11:10], c[4:3], c[12], OPC_BRANCH};
                endcase
            end
            2'b10: begin
                case (c[15:13])
                    3'b000: begin
                        instr_o = {7'b0, c[6:2], c[11:7], 3'b001, c[11:7], OPC_OP_IMM};
                        illegal_instr_o = c[12];
                    end
                    3'b010: begin
                        instr_o = {4'b0, c[3:2], c[12], c[6:4], 2'b00, 5'h02, 3'b010, c[11:7], OPC_LOAD};
                        illegal_instr_o = (c[11:7] == 5'h00);
                    end
                    3'b100: begin
                        if (c[6:2] != 5'h00) begin
                            instr_o = {7'b0, c[6:2], c[12] ? c[11:7] : 5'h00, 3'b000, c[11:7], OPC_OP};
                        end else if (!c[12]) begin
                            instr_o = {12'b0, c[11:7], 3'b000, 5'h00, OPC_JALR};
                            illegal_instr_o = (c[11:7] == 5'h00);
                        end else if (c[11:7] == 5'h00) begin
                            instr_o = 32'h0010_0073;
                        end else begin
                            instr_o = {12'b0, c[11:7], 3'b000, 5'h01, OPC_JALR};
                        end
                    end
                    3'b110: instr_o = {4'b0, c[8:7], c[12], c[6:2], 5'h02, 3'b010, c[11:9], 2'b00, OPC_STORE};
                    default: illegal_instr_o = 1'b1;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/instr_aligner.sv
// Realigns 32-bit fetch words into 16/32-bit instructions, expands them and
// presents them to ID through one registered valid/ready stage.
module instr_aligner
    import instr_aligner_pkg::*;
#(
    parameter logic [31:0] BOOT_ADDR = BOOT_ADDR_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        fetch_valid_i,
    output logic        fetch_ready_o,
    input  logic [31:0] fetch_rdata_i,
    input  logic        fetch_err_i,
    input  logic        branch_i,
    input  logic [31:0] branch_addr_i,
    output logic        instr_valid_o,
    input  logic        id_ready_i,
    output logic [31:0] instr_rdata_o,
    output logic [31:0] instr_raw_o,
    output logic        instr_is_compressed_o,
    output logic        instr_illegal_c_o,
    output logic        instr_err_o,
    output logic [31:0] instr_pc_o
);

    align_state_e state_q, state_next;
    logic [15:0]  res_q, res_next;
    logic         res_err_q, res_err_next;
    logic [31:0]  pc_q, pc_next;

    logic         adv;
    logic         res_is_c;
    logic [15:0]  lo, hi;
    logic         emit;
    logic [31:0]  raw;
    logic         raw_err;
    logic [31:0]  dec_instr;
    logic         dec_is_c;
    logic         dec_illegal;
    logic         unused_addr_bit;

    assign adv             = !instr_valid_o || id_ready_i;
    assign res_is_c        = is_compressed(res_q);
    assign lo              = fetch_rdata_i[15:0];
    assign hi              = fetch_rdata_i[31:16];
    assign unused_addr_bit = branch_addr_i[0];

    // A compressed residual is emitted on its own, so the word on the bus must wait.
    assign fetch_ready_o = adv && !branch_i && !(state_q == RESID && res_is_c);

    always_comb begin
        state_next   = state_q;
        res_next     = res_q;
        res_err_next = res_err_q;
        pc_next      = pc_q;
        emit         = 1'b0;
        raw          = 32'h0;
        raw_err      = 1'b0;
        case (state_q)
            ALIGNED: begin
                if (fetch_valid_i) begin
                    emit    = 1'b1;
                    raw_err = fetch_err_i;
                    if (is_compressed(lo)) begin
                        raw          = {16'h0, lo};
                        res_next     = hi;
                        res_err_next = fetch_err_i;
                        state_next   = RESID;
                        pc_next      = pc_q + 32'd2;
                    end else begin
                        raw     = fetch_rdata_i;
                        pc_next = pc_q + 32'd4;
                    end
                end
            end
            RESID: begin
                if (res_is_c) begin
                    emit       = 1'b1;
                    raw        = {16'h0, res_q};
                    raw_err    = res_err_q;
                    state_next = ALIGNED;
                    pc_next    = pc_q + 32'd2;
                end else if (fetch_valid_i) begin
                    emit         = 1'b1;
                    raw          = {lo, res_q};
                    raw_err      = res_err_q | fetch_err_i;
                    res_next     = hi;
                    res_err_next = fetch_err_i;
                    pc_next      = pc_q + 32'd4;
                end
            end
            SKIP: begin
                if (fetch_valid_i) begin
                    if (is_compressed(hi)) begin
                        emit       = 1'b1;
                        raw        = {16'h0, hi};
                        raw_err    = fetch_err_i;
                        state_next = ALIGNED;
                        pc_next    = pc_q + 32'd2;
                    end else begin
                        res_next     = hi;
                        res_err_next = fetch_err_i;
                        state_next   = RESID;
                    end
                end
            end
            default: state_next = ALIGNED;
        endcase
    end

    compressed_decoder u_decoder (
        .instr_i         (raw),
        .instr_o         (dec_instr),
        .is_compressed_o (dec_is_c),
        .illegal_instr_o (dec_illegal)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q               <= ALIGNED;
            res_q                 <= 16'h0;
            res_err_q             <= 1'b0;
            pc_q                  <= BOOT_ADDR;
            instr_valid_o         <= 1'b0;
            instr_rdata_o         <= 32'h0;
            instr_raw_o           <= 32'h0;
            instr_is_compressed_o <= 1'b0;
            instr_illegal_c_o     <= 1'b0;
            instr_err_o           <= 1'b0;
            instr_pc_o            <= 32'h0;
        end else if (branch_i) begin
            state_q       <= branch_addr_i[1] ? SKIP : ALIGNED;
            res_q         <= 16'h0;
            res_err_q     <= 1'b0;
            pc_q          <= {branch_addr_i[31:1], 1'b0};
            instr_valid_o <= 1'b0;
        end else if (adv) begin
            state_q       <= state_next;
            res_q         <= res_next;
            res_err_q     <= res_err_next;
            pc_q          <= pc_next;
            instr_valid_o <= emit;
            if (emit) begin
                instr_rdata_o         <= dec_instr;
                instr_raw_o           <= raw;
                instr_is_compressed_o <= dec_is_c;
                instr_illegal_c_o     <= dec_illegal;
                instr_err_o           <= raw_err;
                instr_pc_o            <= pc_q;
            end
        end
    end

endmodule

// File: tb/tb_instr_aligner.sv
// Self-checking bench for instr_aligner: directed scenarios plus a randomized
// halfword-stream reference model with random fetch/ID handshakes.
module tb_instr_aligner;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        fetch_valid_i = 1'b0;
    logic        fetch_ready_o;
    logic [31:0] fetch_rdata_i = 32'h0;
    logic        fetch_err_i = 1'b0;
    logic        branch_i = 1'b0;
    logic [31:0] branch_addr_i = 32'h0;
    logic        instr_valid_o;
    logic        id_ready_i = 1'b1;
    logic [31:0] instr_rdata_o;
    logic [31:0] instr_raw_o;
    logic        instr_is_compressed_o;
    logic        instr_illegal_c_o;
    logic        instr_err_o;
    logic [31:0] instr_pc_o;

    int n_checks = 0;
    int n_fail   = 0;

    // Hand-expanded RVC encodings: c.li a0,0 / c.li a0,1 / c.nop / c.addi a0,1 /
    // c.mv a0,a1 / c.ebreak / c.jr ra / c.lw a0,0(a1)
    logic [15:0] ctab [8] = '{16'h4501, 16'h4505, 16'h0001, 16'h0505,
                              16'h852E, 16'h9002, 16'h8082, 16'h4188};
    logic [31:0] cexp [8] = '{32'h0000_0513, 32'h0010_0513, 32'h0000_0013, 32'h0015_0513,
                              32'h00B0_0533, 32'h0010_0073, 32'h0000_8067, 32'h0005_A503};

    typedef struct {
        logic [31:0] pc;
        logic [31:0] raw;
        logic [31:0] rdata;
        logic        c;
        int          hidx;
        int          nhw;
    } exp_t;

    always #5 clk_i = ~clk_i;

    instr_aligner #(.BOOT_ADDR(32'h0000_0080)) dut (
        .clk_i                 (clk_i),
        .rst_i                 (rst_i),
        .fetch_valid_i         (fetch_valid_i),
        .fetch_ready_o         (fetch_ready_o),
        .fetch_rdata_i         (fetch_rdata_i),
        .fetch_err_i           (fetch_err_i),
        .branch_i              (branch_i),
        .branch_addr_i         (branch_addr_i),
        .instr_valid_o         (instr_valid_o),
        .id_ready_i            (id_ready_i),
        .instr_rdata_o         (instr_rdata_o),
        .instr_raw_o           (instr_raw_o),
        .instr_is_compressed_o (instr_is_compressed_o),
        .instr_illegal_c_o     (instr_illegal_c_o),
        .instr_err_o           (instr_err_o),
        .instr_pc_o            (instr_pc_o)
    );

    function automatic logic [99:0] obs();
        return {instr_valid_o, instr_pc_o, instr_raw_o, instr_rdata_o,
                instr_is_compressed_o, instr_illegal_c_o, instr_err_o};
    endfunction

    function automatic logic [99:0] pack(input logic v, input logic [31:0] pc, input logic [31:0] raw,
                                         input logic [31:0] rdata, input logic c, input logic ill,
                                         input logic err);
        return {v, pc, raw, rdata, c, ill, err};
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_branch(input logic [31:0] addr);
        branch_i      = 1'b1;
        branch_addr_i = addr;
        tick();
        branch_i      = 1'b0;
    endtask

    task automatic test_reset();
        logic [99:0] e;
        rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        e = pack(0, 0, 0, 0, 0, 0, 0);
        n_checks++;
        if (obs() !== e) begin n_fail++; $display("FAIL reset_outputs: got %h want %h", obs(), e); end
        rst_i = 1'b0;
        #1;
        n_checks++;
        if (fetch_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_fetch_ready: got %b want 1", fetch_ready_o); end
    endtask

    task automatic test_two_compressed();
        logic [99:0] e;
        fetch_valid_i = 1'b1; fetch_rdata_i = 32'h0001_4501; fetch_err_i = 1'b0; id_ready_i = 1'b1;
        tick();
        fetch_valid_i = 1'b0;
        e = pack(1, 32'h80, 32'h0000_4501, 32'h0000_0513, 1, 0, 0);
        n_checks++;
        if (obs() !== e) begin n_fail++; $display("FAIL two_c_first: got %h want %h", obs(), e); end
        #1;
        n_checks++;
        if (fetch_ready_o !== 1'b0) begin n_fail++; $display("FAIL two_c_ready: got %b want 0", fetch_ready_o); end
        tick();
        e = pack(1, 32'h82, 32'h0000_0001, 32'h0000_0013, 1, 0, 0);
        n_checks++;
        if (obs() !== e) begin n_fail++; $display("FAIL two_c_second: got %h want %h", obs(), e); end
    endtask

    task automatic test_straddle();
        logic [99:0] e;
        do_branch(32'h80);
        fetch_valid_i = 1'b1; fetch_rdata_i = 32'h0513_4501;
        tick();
        e = pack(1, 32'h80, 32'h0000_4501, 32'h0000_0513, 1, 0, 0);
        n_checks++;
        if (obs() !== e) begin n_fail++; $display("FAIL straddle_first: got %h want %h", obs(), e); end
        fetch_rdata_i = 32'h4505_0000;
        tick();
        fetch_valid_i = 1'b0;
        e = pack(1, 32'h82, 32'h0000_0513, 32'h0000_0513, 0, 0, 0);
        n_checks++;
        if (obs() !== e) begin n_fail++; $display("FAIL straddle_32: got %h want %h", obs(), e); end
        tick();
        e = pack(1, 32'h86, 32'h0000_4505, 32'h0010_0513, 1, 0, 0);
        n_checks++;
        if (obs() !== e) begin n_fail++; $display("FAIL straddle_tail: got %h want %h", obs(), e); end
    endtask

    task automatic test_odd_branch();
        logic [99:0] e;
        fetch_valid_i = 1'b1; fetch_rdata_i = 32'h4505_FFFF;
        branch_i = 1'b1; branch_addr_i = 32'h102;
        #1;
        n_checks++;
        if (fetch_ready_o !== 1'b0) begin n_fail++; $display("FAIL branch_blocks_fetch: got %b want 0", fetch_ready_o); end
        tick();
        branch_i = 1'b0;
        n_checks++;
        if (instr_valid_o !== 1'b0) begin n_fail++; $display("FAIL branch_clears_valid: got %b want 0", instr_valid_o); end
        tick();
        fetch_valid_i = 1'b0;
        e = pack(1, 32'h102, 32'h0000_4505, 32'h0010_0513, 1, 0, 0);
        n_checks++;
        if (obs() !== e) begin n_fail++; $display("FAIL odd_target: got %h want %h", obs(), e); end
        tick();
        n_checks++;
        if (instr_valid_o !== 1'b0) begin n_fail++; $display("FAIL odd_single: got %b want 0", instr_valid_o); end
    endtask

    task automatic test_backpressure_flush();
        logic [99:0] e;
        do_branch(32'h200);
        fetch_valid_i = 1'b1; fetch_rdata_i = 32'h4505_4501;
        tick();
        id_ready_i = 1'b0; fetch_rdata_i = 32'h1234_5678;
        e = pack(1, 32'h200, 32'h0000_4501, 32'h0000_0513, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (obs() !== e) begin n_fail++; $display("FAIL stall_hold%0d: got %h want %h", i, obs(), e); end
            #1;
            n_checks++;
            if (fetch_ready_o !== 1'b0) begin n_fail++; $display("FAIL stall_ready%0d: got %b want 0", i, fetch_ready_o); end
            tick();
        end
        fetch_valid_i = 1'b0;
        do_branch(32'h300);
        n_checks++;
        if (instr_valid_o !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b want 0", instr_valid_o); end
        id_ready_i = 1'b1; fetch_valid_i = 1'b1; fetch_rdata_i = 32'h0001_4501;
        tick();
        fetch_valid_i = 1'b0;
        tick();
        e = pack(1, 32'h302, 32'h0000_0001, 32'h0000_0013, 1, 0, 0);
        n_checks++;
        if (obs() !== e) begin n_fail++; $display("FAIL flush_resid_gone: got %h want %h", obs(), e); end
    endtask

    task automatic test_error_illegal();
        logic [99:0] e;
        do_branch(32'h80);
        fetch_valid_i = 1'b1; fetch_rdata_i = 32'h0; fetch_err_i = 1'b0;
        tick();
        fetch_valid_i = 1'b0;
        n_checks++;
        if ({instr_valid_o, instr_pc_o, instr_illegal_c_o} !== {1'b1, 32'h80, 1'b1}) begin
            n_fail++; $display("FAIL illegal_lo: got v=%b pc=%h ill=%b want v=1 pc=80 ill=1",
                               instr_valid_o, instr_pc_o, instr_illegal_c_o);
        end
        tick();
        n_checks++;
        if ({instr_valid_o, instr_pc_o, instr_illegal_c_o} !== {1'b1, 32'h82, 1'b1}) begin
            n_fail++; $display("FAIL illegal_hi: got v=%b pc=%h ill=%b want v=1 pc=82 ill=1",
                               instr_valid_o, instr_pc_o, instr_illegal_c_o);
        end
        fetch_valid_i = 1'b1; fetch_rdata_i = 32'h0513_0001;
        tick();
        fetch_rdata_i = 32'h0001_0000; fetch_err_i = 1'b1;
        tick();
        fetch_valid_i = 1'b0; fetch_err_i = 1'b0;
        e = pack(1, 32'h86, 32'h0000_0513, 32'h0000_0513, 0, 0, 1);
        n_checks++;
        if (obs() !== e) begin n_fail++; $display("FAIL err_straddle: got %h want %h", obs(), e); end
        tick();
        e = pack(1, 32'h8A, 32'h0000_0001, 32'h0000_0013, 1, 0, 1);
        n_checks++;
        if (obs() !== e) begin n_fail++; $display("FAIL err_resid: got %h want %h", obs(), e); end
    endtask

    task automatic test_reset_mid_stall();
        logic [99:0] e;
        do_branch(32'h40);
        fetch_valid_i = 1'b1; fetch_rdata_i = 32'h4505_4501;
        tick();
        fetch_valid_i = 1'b0; id_ready_i = 1'b0;
        tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        e = pack(0, 0, 0, 0, 0, 0, 0);
        n_checks++;
        if (obs() !== e) begin n_fail++; $display("FAIL mid_reset_outputs: got %h want %h", obs(), e); end
        id_ready_i = 1'b1; fetch_valid_i = 1'b1; fetch_rdata_i = 32'h0001_4501;
        tick();
        fetch_valid_i = 1'b0;
        e = pack(1, 32'h80, 32'h0000_4501, 32'h0000_0513, 1, 0, 0);
        n_checks++;
        if (obs() !== e) begin n_fail++; $display("FAIL mid_reset_boot: got %h want %h", obs(), e); end
        tick();
        n_checks++;
        if (instr_raw_o !== 32'h0000_0001) begin n_fail++; $display("FAIL mid_reset_resid: got %h want 00000001", instr_raw_o); end
    endtask

    // Reference model: the program is a flat halfword stream starting at the branch
    // target; each instruction's error is the OR of the words holding its halves.
    task automatic test_random(input int seq);
        logic [15:0] hw[$];
        logic [31:0] words[$];
        logic        werr[$];
        exp_t        q[$];
        exp_t        x;
        logic [31:0] r, pc, r32;
        logic [99:0] e;
        logic        rdy, fv, xerr;
        int          k, widx, cyc;

        r  = (seq == 0) ? (32'hFFFF_FFFA | $urandom_range(0, 1)) : $urandom();
        pc = {r[31:1], 1'b0};
        if (r[1]) begin
            r32 = $urandom();
            hw.push_back(r32[15:0]);
        end
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                k = $urandom_range(0, 7);
                q.push_back('{pc, {16'h0, ctab[k]}, cexp[k], 1'b1, hw.size(), 1});
                hw.push_back(ctab[k]);
                pc = pc + 32'd2;
            end else begin
                r32 = $urandom() | 32'h3;
                q.push_back('{pc, r32, r32, 1'b0, hw.size(), 2});
                hw.push_back(r32[15:0]);
                hw.push_back(r32[31:16]);
                pc = pc + 32'd4;
            end
        end
        if (hw.size() % 2 == 1) begin
            q.push_back('{pc, 32'h0000_0001, 32'h0000_0013, 1'b1, hw.size(), 1});
            hw.push_back(16'h0001);
        end
        for (int j = 0; j < hw.size() / 2; j++) begin
            words.push_back({hw[2*j+1], hw[2*j]});
            werr.push_back($urandom_range(0, 7) == 0);
        end

        branch_i = 1'b1; branch_addr_i = r;
        fetch_valid_i = 1'($urandom_range(0, 1)); fetch_rdata_i = $urandom(); id_ready_i = 1'b1;
        #1;
        n_checks++;
        if (fetch_ready_o !== 1'b0) begin n_fail++; $display("FAIL rnd%0d_branch_ready: got %b want 0", seq, fetch_ready_o); end
        tick();
        branch_i = 1'b0;

        widx = 0;
        cyc  = 0;
        while ((q.size() > 0 || widx < words.size()) && cyc < 3000) begin
            rdy = ($urandom_range(0, 3) != 0);
            fv  = (widx < words.size()) && ($urandom_range(0, 3) != 0);
            id_ready_i    = rdy;
            fetch_valid_i = fv;
            fetch_rdata_i = fv ? words[widx] : $urandom();
            fetch_err_i   = fv ? werr[widx] : 1'b0;
            #1;
            if (instr_valid_o && rdy) begin
                n_checks++;
                if (q.size() == 0) begin
                    n_fail++; $display("FAIL rnd%0d_extra: got pc=%h raw=%h want no instruction", seq, instr_pc_o, instr_raw_o);
                end else begin
                    x    = q.pop_front();
                    xerr = werr[x.hidx / 2] | werr[(x.hidx + x.nhw - 1) / 2];
                    e    = pack(1, x.pc, x.raw, x.rdata, x.c, 0, xerr);
                    $display("txn rnd%0d pc=%h raw=%h rdata=%h err=%b", seq, instr_pc_o, instr_raw_o, instr_rdata_o, instr_err_o);
                    if (obs() !== e) begin n_fail++; $display("FAIL rnd%0d_instr: got %h want %h", seq, obs(), e); end
                end
            end
            if (fv && fetch_ready_o) widx++;
            tick();
            cyc++;
        end
        fetch_valid_i = 1'b0;
        id_ready_i    = 1'b1;
        n_checks++;
        if (cyc >= 3000) begin
            n_fail++; $display("FAIL rnd%0d_timeout: got %0d pending want 0", seq, q.size());
        end else if (instr_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL rnd%0d_drain: got valid=%b want 0", seq, instr_valid_o);
        end
    endtask

    initial begin
        test_reset();
        test_two_compressed();
        test_straddle();
        test_odd_branch();
        test_backpressure_flush();
        test_error_illegal();
        test_reset_mid_stall();
        for (int s = 0; s < 5; s++) test_random(s);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
